// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic        adel;
    logic [31:0] pc;
    logic [31:0] word;
  } slot_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: decode-side slot, instruction-memory handshake and redirect port.
interface inst_fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_adel;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  funct;

  modport master (
    input  stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_adel, op, rt, funct
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_adel, op, rt, funct
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues single-outstanding reads and holds
// the returned word in a one-entry slot until decode consumes it.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  slot_t        slot_q;

  logic consume;
  logic slot_free;
  logic can_leave_req;
  logic adel_take;
  logic issue;

  assign consume   = slot_q.valid & ~bus.stall;
  assign slot_free = ~slot_q.valid | ~bus.stall;

  // A misaligned PC turns the would-be request into an address-error marker.
  assign can_leave_req = (state_q == ST_REQ) & slot_free & ~bus.redirect & ~rst;
  assign adel_take     = can_leave_req & misaligned(pc_q);
  assign bus.imem_req  = can_leave_req & ~misaligned(pc_q);
  assign bus.imem_addr = pc_q;
  assign issue         = bus.imem_req & bus.imem_gnt;

  assign bus.inst_valid = slot_q.valid;
  assign bus.inst       = slot_q.word;
  assign bus.inst_pc    = slot_q.pc;
  assign bus.inst_adel  = slot_q.adel;
  assign bus.op         = slot_q.word[31:26];
  assign bus.rt         = slot_q.word[20:16];
  assign bus.funct      = slot_q.word[5:0];

  // NOTE: non-blocking assignments only; later assignments in this block
  // deliberately override earlier ones (slot load beats consume, redirect beats all).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      slot_q  <= '0;
    end else begin
      if (consume) begin
        slot_q.valid <= 1'b0;
      end
      if (bus.redirect) begin
        pc_q         <= bus.redirect_pc;
        slot_q.valid <= 1'b0;
        // An outstanding read that completes on the redirect edge needs no drop phase.
        case (state_q)
          ST_WAIT, ST_DROP: state_q <= bus.imem_rvalid ? ST_REQ : ST_DROP;
          default:          state_q <= ST_REQ;
        endcase
      end else begin
        case (state_q)
          ST_REQ: begin
            if (adel_take) begin
              slot_q  <= '{valid: 1'b1, adel: 1'b1, pc: pc_q, word: 32'd0};
              state_q <= ST_ERR;
            end else if (issue) begin
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (bus.imem_rvalid) begin
              slot_q  <= '{valid: 1'b1, adel: 1'b0, pc: pc_q, word: bus.imem_rdata};
              pc_q    <= pc_q + PC_INC;
              state_q <= ST_REQ;
            end
          end
          ST_DROP: begin
            if (bus.imem_rvalid) begin
              state_q <= ST_REQ;
            end
          end
          default: begin
            state_q <= ST_ERR;
          end
        endcase
      end
    end
  end

endmodule
